// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program-counter sequencer. Holds the PC, drives the
//   branch-target LUT index straight from the instruction's branch field,
//   and forms the next PC from the LUT result as an absolute jump or a
//   PC-relative two's-complement offset. A start/done run handshake and a
//   saturating run-cycle counter serve the test harness.
//
// Ports
//   clk         rising-edge system clock
//   reset       asynchronous, active-high reset
//   start       begin a program run (ignored while running)
//   halt        current instruction is a halt
//   stall       freeze the PC this cycle (beats halt and branch)
//   branch_en   current instruction is a taken branch
//   branch_rel  1: pc + lut_target, 0: lut_target
//   br_idx      LUT index field of the current instruction
//   lut_addr    index to the branch-target LUT (combinational)
//   lut_target  target/offset returned by the LUT in the same cycle
//   pc          current program counter (registered)
//   busy        high while running
//   done        high while finished (level)
//   cycle_cnt   run cycles since the last start, saturating
module pc_sequencer #(
    parameter int D        = 10,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             branch_rel,
    input  logic [3:0]       br_idx,
    output logic [3:0]       lut_addr,
    input  logic [D-1:0]     lut_target,
    output logic [D-1:0]     pc,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [D-1:0] START_VAL = D'(START_PC);

    state_t           state, state_n;
    logic [D-1:0]     pc_n;
    logic [CNT_W-1:0] cnt_n;

    // The LUT is combinational, so its index is just the instruction field.
    assign lut_addr = br_idx;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= START_VAL;
            cycle_cnt <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            cycle_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cycle_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = START_VAL;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                // Every edge in RUN counts, stalled and halting ones included.
                if (cycle_cnt != '1)
                    cnt_n = cycle_cnt + CNT_W'(1);
                if (stall) begin
                    pc_n = pc;
                end else if (halt) begin
                    // PC stays on the halt instruction.
                    state_n = DONE;
                end else if (branch_en) begin
                    // D-bit add wraps, so a two's-complement offset just works.
                    pc_n = branch_rel ? (pc + lut_target) : lut_target;
                end else begin
                    pc_n = pc + D'(1);
                end
            end
            default: begin
                state_n = IDLE;
                pc_n    = START_VAL;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed scenarios followed by randomized traffic, all checked against a
//   cycle-level reference model of the sequencer's behaviour. The counter
//   width is narrowed so saturation shows up within long random runs.
module tb_pc_sequencer;

    localparam int D     = 10;
    localparam int SPC   = 0;
    localparam int CW    = 6;
    localparam int PCMOD = 1 << D;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, halt = 1'b0, stall = 1'b0;
    logic          br_en = 1'b0, br_rel = 1'b0;
    logic [3:0]    br_idx = 4'd0;
    logic [3:0]    lut_addr;
    logic [D-1:0]  lut_target;
    logic [D-1:0]  pc;
    logic          busy, done;
    logic [CW-1:0] cycle_cnt;

    logic [D-1:0]  lut_mem [16];

    int errs   = 0;
    int checks = 0;

    // Reference model state: mode 0 idle, 1 running, 2 finished.
    int m_mode, m_pc, m_cnt;

    always #5 clk = ~clk;

    assign lut_target = lut_mem[lut_addr];

    pc_sequencer #(.D(D), .START_PC(SPC), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .halt       (halt),
        .stall      (stall),
        .branch_en  (br_en),
        .branch_rel (br_rel),
        .br_idx     (br_idx),
        .lut_addr   (lut_addr),
        .lut_target (lut_target),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .cycle_cnt  (cycle_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = SPC;
        m_cnt  = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".pc"},   32'(pc),        32'(m_pc));
        chk({tag, ".busy"}, 32'(busy),      32'(m_mode == 1));
        chk({tag, ".done"}, 32'(done),      32'(m_mode == 2));
        chk({tag, ".cnt"},  32'(cycle_cnt), 32'(m_cnt));
    endtask

    // Inputs are set by the caller; advance one clock and compare.
    task automatic step(input string tag);
        int t;
        #1;
        chk({tag, ".lut_addr"}, 32'(lut_addr), 32'(br_idx));
        t = int'(lut_mem[br_idx]);
        if (m_mode == 1) begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (stall) begin
            end else if (halt) begin
                m_mode = 2;
            end else if (br_en) begin
                m_pc = br_rel ? (m_pc + t) % PCMOD : t;
            end else begin
                m_pc = (m_pc + 1) % PCMOD;
            end
        end else if (start) begin
            m_mode = 1;
            m_pc   = SPC;
            m_cnt  = 0;
        end
        @(posedge clk);
        #1;
        chk_outputs(tag);
    endtask

    task automatic clr_in();
        start = 0; halt = 0; stall = 0; br_en = 0; br_rel = 0; br_idx = 0;
    endtask

    task automatic abs_jump(input string tag, input logic [3:0] idx, input logic [D-1:0] tgt);
        lut_mem[idx] = tgt;
        clr_in(); br_en = 1; br_idx = idx;
        step(tag);
    endtask

    // Pulse reset between clock edges and check outputs before the next edge.
    task automatic mid_reset(input string tag);
        #2 rst = 1;
        #1;
        model_reset();
        chk_outputs(tag);
        #1 rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lut_mem[i] = D'($urandom);
        model_reset();
        clr_in();
        #3;
        chk_outputs("reset");
        @(negedge clk);
        rst = 0;

        // Start, then five plain cycles.
        start = 1; step("start");
        clr_in();
        for (int i = 0; i < 5; i++) step("seq");

        // Absolute branch from pc 7.
        step("seq6"); step("seq7");
        abs_jump("abs114", 4'd3, D'(114));

        // Relative branches, including a wrap past 2^D.
        abs_jump("abs20", 4'd4, D'(20));
        lut_mem[5] = 10'h3FB;
        clr_in(); br_en = 1; br_rel = 1; br_idx = 5; step("rel_m5");
        abs_jump("abs1020", 4'd6, D'(1020));
        lut_mem[7] = D'(20);
        clr_in(); br_en = 1; br_rel = 1; br_idx = 7; step("rel_wrap");

        // Stall beats halt, then halt beats branch.
        clr_in(); stall = 1; halt = 1;
        step("stall_halt1"); step("stall_halt2");
        stall = 0; br_en = 1; br_idx = 3; step("halt_br");
        clr_in(); step("done_hold");

        // Restart from DONE, then sequential wrap.
        start = 1; step("restart");
        abs_jump("abs1023", 4'd8, D'(1023));
        clr_in(); step("seq_wrap");

        // Async reset mid-run at pc 44.
        abs_jump("abs44", 4'd9, D'(44));
        mid_reset("midrst");
        start = 1; step("start_after_rst");
        clr_in(); step("run_after_rst");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            start  = ($urandom_range(0, 9) == 0);
            halt   = ($urandom_range(0, 63) == 0);
            stall  = ($urandom_range(0, 5) == 0);
            br_en  = ($urandom_range(0, 3) == 0);
            br_rel = 1'($urandom);
            br_idx = 4'($urandom);
            if ($urandom_range(0, 7) == 0) lut_mem[$urandom_range(0, 15)] = D'($urandom);
            step("rand");
            if ($urandom_range(0, 299) == 0) mid_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
